// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding-select and load-use hazard controller beside the ID/EX register.
// Selects and bubble are registered (1 cycle); stall is combinational and lasts at most one cycle per hazard.
module fwd_hazard_ctrl #(
  parameter int RA_W     = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_use_imm,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [1:0]       ex_sel1,
  output logic [1:0]       ex_sel2,
  output logic             stall,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, STALL} state_t;

  state_t          state;
  logic            ex_v, ex_wr, ex_ld;
  logic [RA_W-1:0] ex_rd;
  // WB producers are covered by the write-first register file, so only EX and MEM are kept.
  logic            mem_v, mem_wr;
  logic [RA_W-1:0] mem_rd;

  logic       m_ex1, m_ex2, m_mem1, m_mem2;
  logic       hz, issue;
  logic [1:0] sel1_nxt, sel2_nxt;

  function automatic logic src_match(input logic v, input logic wr, input logic [RA_W-1:0] rd,
                                     input logic [RA_W-1:0] rs, input logic use_rs);
    return v & wr & use_rs & (rd == rs) & ~(ZERO_REG & (rs == '0));
  endfunction

  always_comb begin
    m_ex1  = src_match(ex_v, ex_wr, ex_rd, id_rs1, id_use_rs1);
    m_ex2  = src_match(ex_v, ex_wr, ex_rd, id_rs2, id_use_rs2);
    m_mem1 = src_match(mem_v, mem_wr, mem_rd, id_rs1, id_use_rs1);
    m_mem2 = src_match(mem_v, mem_wr, mem_rd, id_rs2, id_use_rs2);

    hz    = id_valid & ex_ld & (m_ex1 | (m_ex2 & ~id_use_imm));
    stall = (state == RUN) & hz & ~flush;
    issue = id_valid & ~stall & ~flush;

    sel1_nxt = 2'd0;
    if (m_ex1)       sel1_nxt = 2'd1;
    else if (m_mem1) sel1_nxt = 2'd2;

    sel2_nxt = 2'd0;
    if (id_use_imm)  sel2_nxt = 2'd3;
    else if (m_ex2)  sel2_nxt = 2'd1;
    else if (m_mem2) sel2_nxt = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      ex_v        <= 1'b0;
      ex_wr       <= 1'b0;
      ex_ld       <= 1'b0;
      ex_rd       <= '0;
      mem_v       <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd      <= '0;
      ex_sel1     <= 2'd0;
      ex_sel2     <= 2'd0;
      ex_bubble   <= 1'b1;
      stall_count <= '0;
    end else begin
      mem_v  <= ex_v;
      mem_wr <= ex_wr;
      mem_rd <= ex_rd;
      if (issue) begin
        ex_v    <= 1'b1;
        ex_wr   <= id_wr_en;
        ex_ld   <= id_is_load;
        ex_rd   <= id_rd;
        ex_sel1 <= sel1_nxt;
        ex_sel2 <= sel2_nxt;
      end else begin
        ex_v    <= 1'b0;
        ex_wr   <= 1'b0;
        ex_ld   <= 1'b0;
        ex_rd   <= '0;
        ex_sel1 <= 2'd0;
        ex_sel2 <= 2'd0;
      end
      ex_bubble <= ~issue;
      // The bubble guarantees no hazard in the cycle after a stall; STALL just returns to RUN.
      state <= stall ? STALL : RUN;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed test-plan sequences plus random instruction streams
// compared each cycle against an in-flight instruction model.
module tb_fwd_hazard_ctrl;
  localparam int RA_W  = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs1, id_use_rs2, id_use_imm, id_wr_en, id_is_load, flush;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0] ex_sel1, ex_sel2;
  logic stall, ex_bubble;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.RA_W(RA_W), .ZERO_REG(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_use_imm(id_use_imm),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .ex_sel1(ex_sel1), .ex_sel2(ex_sel2), .stall(stall), .ex_bubble(ex_bubble),
    .stall_count(stall_count)
  );

  typedef struct {bit v; bit wr; bit ld; int rd;} instr_t;

  instr_t in_ex, in_mem;
  int     sel1_m, sel2_m, cnt_m;
  bit     bub_m;
  int     nvec = 0;
  int     nerr = 0;
  bit     obs_stall;
  bit     stall_m;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit produces(instr_t p, int rs, bit use_rs);
    return use_rs && p.v && p.wr && p.rd == rs && rs != 0;
  endfunction

  function automatic int fwd_src(int rs, bit use_rs);
    if (produces(in_ex, rs, use_rs))  return 1;
    if (produces(in_mem, rs, use_rs)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    in_ex  = '{0, 0, 0, 0};
    in_mem = '{0, 0, 0, 0};
    sel1_m = 0; sel2_m = 0; bub_m = 1; cnt_m = 0;
  endtask

  // Inputs are already driven; check the stall, clock once, check registered outputs.
  task automatic step();
    bit load_use, go;
    int s1, s2;
    #1;
    load_use = id_valid && in_ex.ld &&
               (produces(in_ex, id_rs1, id_use_rs1) || (produces(in_ex, id_rs2, id_use_rs2) && !id_use_imm));
    stall_m = load_use && !flush;
    obs_stall = stall;
    chk("stall", stall, stall_m);
    go = id_valid && !stall_m && !flush;
    s1 = go ? fwd_src(id_rs1, id_use_rs1) : 0;
    s2 = !go ? 0 : id_use_imm ? 3 : fwd_src(id_rs2, id_use_rs2);
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      in_mem = in_ex;
      in_ex  = go ? '{1, id_wr_en, id_is_load, int'(id_rd)} : '{0, 0, 0, 0};
      sel1_m = s1; sel2_m = s2; bub_m = !go;
      if (stall_m && cnt_m < (1 << CNT_W) - 1) cnt_m++;
    end
    chk("ex_sel1", ex_sel1, sel1_m);
    chk("ex_sel2", ex_sel2, sel2_m);
    chk("ex_bubble", ex_bubble, bub_m);
    chk("stall_count", stall_count, cnt_m);
  endtask

  task automatic ins(input bit v, input int rd, input int rs1, input int rs2, input bit u1, input bit u2,
                     input bit imm, input bit wr, input bit ld, input bit fl);
    @(negedge clk);
    id_valid = v; id_rd = RA_W'(rd); id_rs1 = RA_W'(rs1); id_rs2 = RA_W'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_use_imm = imm; id_wr_en = wr; id_is_load = ld; flush = fl;
    step();
  endtask

  task automatic add(input int rd, input int rs1, input int rs2);
    ins(1, rd, rs1, rs2, 1, 1, 0, 1, 0, 0);
  endtask

  task automatic nop();
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sel1"}, ex_sel1, 0);
    chk({tag, "_sel2"}, ex_sel2, 0);
    chk({tag, "_bubble"}, ex_bubble, 1);
    chk({tag, "_cnt"}, stall_count, 0);
    chk({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    bit held;
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_use_imm = 0; id_wr_en = 0; id_is_load = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    add(3, 1, 2); add(4, 3, 5);
    chk("b2b_sel1", ex_sel1, 1); chk("b2b_sel2", ex_sel2, 0); chk("b2b_stall", obs_stall, 0);

    add(3, 1, 2); nop(); add(6, 5, 3);
    chk("gap_sel2", ex_sel2, 2);
    add(3, 1, 2); nop(); ins(1, 6, 5, 3, 1, 0, 1, 1, 0, 0);
    chk("imm_sel2", ex_sel2, 3);

    add(3, 1, 2); add(3, 1, 2); add(7, 3, 1);
    chk("youngest_sel1", ex_sel1, 1);

    ins(1, 2, 1, 0, 1, 0, 1, 1, 1, 0);
    add(4, 2, 1);
    chk("ld_stall", obs_stall, 1); chk("ld_bubble", ex_bubble, 1);
    add(4, 2, 1);
    chk("ld_held_stall", obs_stall, 0); chk("ld_sel1", ex_sel1, 2); chk("ld_cnt", stall_count, 1);

    ins(1, 2, 1, 0, 1, 0, 1, 1, 1, 0);
    ins(1, 4, 2, 1, 1, 1, 0, 1, 0, 1);
    chk("flush_stall", obs_stall, 0); chk("flush_bubble", ex_bubble, 1); chk("flush_cnt", stall_count, 1);

    add(0, 1, 2); add(5, 0, 1);
    chk("zero_sel1", ex_sel1, 0); chk("zero_stall", obs_stall, 0);

    ins(1, 2, 1, 0, 1, 0, 1, 1, 1, 0);
    add(4, 2, 1);
    chk("pre_rst_stall", obs_stall, 1);
    rst = 1'b1;
    add(4, 2, 1);
    rst = 1'b0;
    check_reset_vals("mid_stall_rst");

    held = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!held) begin
        id_valid   = ($urandom_range(0, 9) < 8);
        id_rs1     = RA_W'($urandom_range(0, 3));
        id_rs2     = RA_W'($urandom_range(0, 3));
        id_rd      = RA_W'($urandom_range(0, 3));
        id_use_rs1 = $urandom_range(0, 1);
        id_use_rs2 = $urandom_range(0, 1);
        id_use_imm = ($urandom_range(0, 3) == 0);
        id_wr_en   = ($urandom_range(0, 3) != 0);
        id_is_load = ($urandom_range(0, 2) == 0);
      end
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      step();
      held = stall_m;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
